// File: rtl/hazard_scoreboard_if.sv
// Bundle between the decode stage and the hazard scoreboard: ID operands,
// write-back completions, fetch-cancel inputs and the stall/discard results.
interface hazard_scoreboard_if #(
    parameter int NREG  = 32,
    parameter int LAT_W = 4,
    parameter int CNT_W = 3
);
    localparam int RW = $clog2(NREG);

    logic             id_valid;
    logic [RW-1:0]    id_rj;
    logic [RW-1:0]    id_rk;
    logic [RW-1:0]    id_rd;
    logic             id_use_rj;
    logic             id_use_rk;
    logic             id_use_rd;
    logic             id_wr_en;
    logic [LAT_W-1:0] id_wr_lat;
    logic             id_br_taken;
    logic             ex_allow_in;
    logic             wb_done;
    logic [RW-1:0]    wb_rd;
    logic             flush;
    logic [CNT_W-1:0] if_outstanding;
    logic             inst_data_ok;
    logic             id_stall;
    logic             id_fire;
    logic             if_discard;
    logic [NREG-1:0]  busy_vec;
    logic             cancel_pending;

    modport master (
        output id_valid, id_rj, id_rk, id_rd, id_use_rj, id_use_rk, id_use_rd,
               id_wr_en, id_wr_lat, id_br_taken, ex_allow_in, wb_done, wb_rd,
               flush, if_outstanding, inst_data_ok,
        input  id_stall, id_fire, if_discard, busy_vec, cancel_pending
    );

    modport slave (
        input  id_valid, id_rj, id_rk, id_rd, id_use_rj, id_use_rk, id_use_rd,
               id_wr_en, id_wr_lat, id_br_taken, ex_allow_in, wb_done, wb_rd,
               flush, if_outstanding, inst_data_ok,
        output id_stall, id_fire, if_discard, busy_vec, cancel_pending
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write latency scoreboard with ID stall/issue decisions
// and a wrong-path fetch-response cancel counter.
module hazard_scoreboard #(
    parameter int NREG  = 32,
    parameter int LAT_W = 4,
    parameter int CNT_W = 3
) (
    input  logic                aclk,
    input  logic                reset,
    hazard_scoreboard_if.slave  sb
);
    localparam int RW = $clog2(NREG);
    localparam logic [LAT_W-1:0] VAR    = {LAT_W{1'b1}};
    localparam logic [CNT_W-1:0] CC_MAX = {CNT_W{1'b1}};

    logic [NREG-1:0][LAT_W-1:0] cnt_r;
    logic [NREG-1:0][LAT_W-1:0] cnt_nxt_s;
    logic [NREG-1:0]            busy_s;
    logic [CNT_W-1:0]           cc_r;
    logic [CNT_W-1:0]           cc_nxt_s;
    logic [CNT_W:0]             cc_sum_s;
    logic [CNT_W-1:0]           cc_load_val_s;
    logic                       cc_load_s;
    logic                       stall_s;
    logic                       fire_s;

    // Busy flags straight from the latency counters.
    always_comb begin
        busy_s = {NREG{1'b0}};
        for (int r = 0; r < NREG; r++) begin
            busy_s[r] = (cnt_r[r] != {LAT_W{1'b0}});
        end
    end

    // RAW on any read operand, or WAW against an unresolved variable-latency write.
    always_comb begin
        stall_s = 1'b0;
        if (sb.id_valid) begin
            stall_s = (sb.id_use_rj & busy_s[sb.id_rj])
                    | (sb.id_use_rk & busy_s[sb.id_rk])
                    | (sb.id_use_rd & busy_s[sb.id_rd])
                    | (sb.id_wr_en  & (cnt_r[sb.id_rd] == VAR));
        end else begin
            stall_s = 1'b0;
        end
    end

    assign fire_s = sb.id_valid & sb.ex_allow_in & ~stall_s & ~sb.flush;

    // Next counter value per register: flush, issue load, wb clear, decrement.
    always_comb begin
        cnt_nxt_s = cnt_r;
        for (int r = 0; r < NREG; r++) begin
            if (r == 0) begin
                cnt_nxt_s[r] = {LAT_W{1'b0}};
            end else if (sb.flush) begin
                cnt_nxt_s[r] = {LAT_W{1'b0}};
            end else if (fire_s && sb.id_wr_en && (sb.id_rd == RW'(r))) begin
                cnt_nxt_s[r] = sb.id_wr_lat;
            end else if (sb.wb_done && (sb.wb_rd == RW'(r)) && (cnt_r[r] == VAR)) begin
                cnt_nxt_s[r] = {LAT_W{1'b0}};
            end else if ((cnt_r[r] != {LAT_W{1'b0}}) && (cnt_r[r] != VAR)) begin
                cnt_nxt_s[r] = cnt_r[r] - LAT_W'(1);
            end else begin
                cnt_nxt_s[r] = cnt_r[r];
            end
        end
    end

    // Responses still owed to the wrong path; the current one counts if not yet back.
    always_comb begin
        cc_sum_s      = {1'b0, sb.if_outstanding} + {{CNT_W{1'b0}}, ~sb.inst_data_ok};
        cc_load_val_s = cc_sum_s[CNT_W] ? CC_MAX : cc_sum_s[CNT_W-1:0];
        cc_load_s     = sb.flush | (fire_s & sb.id_br_taken);
        if (cc_load_s) begin
            cc_nxt_s = cc_load_val_s;
        end else if (sb.inst_data_ok && (cc_r != {CNT_W{1'b0}})) begin
            cc_nxt_s = cc_r - CNT_W'(1);
        end else begin
            cc_nxt_s = cc_r;
        end
    end

    // Counter state registers.
    always_ff @(posedge aclk) begin
        if (reset) begin
            cnt_r <= {(NREG*LAT_W){1'b0}};
            cc_r  <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
            cc_r  <= cc_nxt_s;
        end
    end

    assign sb.id_stall       = stall_s;
    assign sb.id_fire        = fire_s;
    assign sb.busy_vec       = busy_s;
    assign sb.cancel_pending = (cc_r != {CNT_W{1'b0}});
    assign sb.if_discard     = sb.inst_data_ok & (cc_r != {CNT_W{1'b0}});
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_hazard_scoreboard;
    localparam int NREG  = 32;
    localparam int LAT_W = 4;
    localparam int CNT_W = 3;
    localparam logic [LAT_W-1:0] VAR = 4'd15;

    logic aclk;
    logic reset;
    int   errors;
    int   checks;

    hazard_scoreboard_if #(.NREG(NREG), .LAT_W(LAT_W), .CNT_W(CNT_W)) bus ();

    hazard_scoreboard #(.NREG(NREG), .LAT_W(LAT_W), .CNT_W(CNT_W)) dut (
        .aclk  (aclk),
        .reset (reset),
        .sb    (bus.slave)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic idle();
        bus.id_valid       = 1'b0;
        bus.id_rj          = 5'd0;
        bus.id_rk          = 5'd0;
        bus.id_rd          = 5'd0;
        bus.id_use_rj      = 1'b0;
        bus.id_use_rk      = 1'b0;
        bus.id_use_rd      = 1'b0;
        bus.id_wr_en       = 1'b0;
        bus.id_wr_lat      = 4'd0;
        bus.id_br_taken    = 1'b0;
        bus.ex_allow_in    = 1'b1;
        bus.wb_done        = 1'b0;
        bus.wb_rd          = 5'd0;
        bus.flush          = 1'b0;
        bus.if_outstanding = 3'd0;
        bus.inst_data_ok   = 1'b0;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic issue_write(input logic [4:0] rd, input logic [LAT_W-1:0] lat);
        idle();
        bus.id_valid  = 1'b1;
        bus.id_wr_en  = 1'b1;
        bus.id_rd     = rd;
        bus.id_wr_lat = lat;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        bus.inst_data_ok = 1'b1;
        #1;
        checks++;
        if (bus.busy_vec !== 32'd0) begin
            errors++; $display("FAIL reset_busy: got %h expected 0", bus.busy_vec);
        end
        checks++;
        if (bus.cancel_pending !== 1'b0 || bus.if_discard !== 1'b0) begin
            errors++; $display("FAIL reset_cancel: got pend=%b disc=%b expected 0 0", bus.cancel_pending, bus.if_discard);
        end
        tick();
        idle();
    endtask

    task automatic test_load_use();
        issue_write(5'd5, 4'd2);
        #1;
        checks++;
        if (bus.id_fire !== 1'b1) begin
            errors++; $display("FAIL lu_issue: got fire=%b expected 1", bus.id_fire);
        end
        tick();
        idle();
        bus.id_valid  = 1'b1;
        bus.id_rj     = 5'd5;
        bus.id_use_rj = 1'b1;
        // Counter reads 2 then 1: two stall cycles before the reader issues.
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (bus.id_stall !== 1'b1 || bus.id_fire !== 1'b0 || bus.busy_vec[5] !== 1'b1) begin
                errors++; $display("FAIL lu_stall%0d: got stall=%b fire=%b busy5=%b expected 1 0 1", i, bus.id_stall, bus.id_fire, bus.busy_vec[5]);
            end
            tick();
        end
        #1;
        checks++;
        if (bus.id_stall !== 1'b0 || bus.id_fire !== 1'b1 || bus.busy_vec[5] !== 1'b0) begin
            errors++; $display("FAIL lu_release: got stall=%b fire=%b busy5=%b expected 0 1 0", bus.id_stall, bus.id_fire, bus.busy_vec[5]);
        end
        tick();
        idle();
    endtask

    task automatic test_var_latency();
        int n_stall;
        int n_fire;
        issue_write(5'd7, VAR);
        tick();
        idle();
        bus.id_valid  = 1'b1;
        bus.id_rk     = 5'd7;
        bus.id_use_rk = 1'b1;
        n_stall = 0;
        n_fire  = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.id_stall === 1'b1) n_stall++;
            if (bus.id_fire === 1'b1) n_fire++;
            tick();
        end
        checks++;
        if (n_stall != 20 || n_fire != 0) begin
            errors++; $display("FAIL var_hold: got stalls=%0d fires=%0d expected 20 0", n_stall, n_fire);
        end
        bus.wb_done = 1'b1;
        bus.wb_rd   = 5'd7;
        tick();
        bus.wb_done = 1'b0;
        #1;
        checks++;
        if (bus.id_stall !== 1'b0 || bus.id_fire !== 1'b1 || bus.busy_vec[7] !== 1'b0) begin
            errors++; $display("FAIL var_release: got stall=%b fire=%b busy7=%b expected 0 1 0", bus.id_stall, bus.id_fire, bus.busy_vec[7]);
        end
        tick();
        // WAW against an outstanding variable-latency write.
        issue_write(5'd7, VAR);
        tick();
        issue_write(5'd7, 4'd0);
        #1;
        checks++;
        if (bus.id_stall !== 1'b1 || bus.id_fire !== 1'b0) begin
            errors++; $display("FAIL waw_stall: got stall=%b fire=%b expected 1 0", bus.id_stall, bus.id_fire);
        end
        bus.wb_done = 1'b1;
        bus.wb_rd   = 5'd7;
        tick();
        bus.wb_done = 1'b0;
        #1;
        checks++;
        if (bus.id_stall !== 1'b0 || bus.id_fire !== 1'b1) begin
            errors++; $display("FAIL waw_release: got stall=%b fire=%b expected 0 1", bus.id_stall, bus.id_fire);
        end
        tick();
        idle();
        #1;
        checks++;
        if (bus.busy_vec !== 32'd0) begin
            errors++; $display("FAIL lat0_not_busy: got %h expected 0", bus.busy_vec);
        end
        tick();
    endtask

    task automatic test_r0_priority();
        issue_write(5'd0, 4'd3);
        tick();
        idle();
        #1;
        checks++;
        if (bus.busy_vec !== 32'd0) begin
            errors++; $display("FAIL r0_busy: got %h expected 0", bus.busy_vec);
        end
        // Issue load wins over a same-cycle wb_done on the same register.
        issue_write(5'd3, 4'd2);
        bus.wb_done = 1'b1;
        bus.wb_rd   = 5'd3;
        tick();
        idle();
        #1;
        checks++;
        if (bus.busy_vec[3] !== 1'b1) begin
            errors++; $display("FAIL prio_busy_c1: got busy3=%b expected 1", bus.busy_vec[3]);
        end
        tick();
        checks++;
        if (bus.busy_vec[3] !== 1'b1) begin
            errors++; $display("FAIL prio_busy_c2: got busy3=%b expected 1", bus.busy_vec[3]);
        end
        tick();
        checks++;
        if (bus.busy_vec[3] !== 1'b0) begin
            errors++; $display("FAIL prio_busy_c3: got busy3=%b expected 0", bus.busy_vec[3]);
        end
        // wb_done on a fixed-latency counter is ignored.
        issue_write(5'd8, 4'd3);
        tick();
        idle();
        bus.wb_done = 1'b1;
        bus.wb_rd   = 5'd8;
        tick();
        bus.wb_done = 1'b0;
        #1;
        checks++;
        if (bus.busy_vec[8] !== 1'b1) begin
            errors++; $display("FAIL wb_ignored: got busy8=%b expected 1", bus.busy_vec[8]);
        end
        tick();
        tick();
        checks++;
        if (bus.busy_vec[8] !== 1'b0) begin
            errors++; $display("FAIL wb_ignored_drain: got busy8=%b expected 0", bus.busy_vec[8]);
        end
    endtask

    task automatic test_branch_cancel();
        int n_disc;
        idle();
        bus.id_valid       = 1'b1;
        bus.id_br_taken    = 1'b1;
        bus.if_outstanding = 3'd2;
        bus.inst_data_ok   = 1'b0;
        #1;
        checks++;
        if (bus.id_fire !== 1'b1) begin
            errors++; $display("FAIL br_fire: got %b expected 1", bus.id_fire);
        end
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            bus.inst_data_ok = 1'b1;
            #1;
            checks++;
            if (bus.if_discard !== ((i < 3) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL br_discard%0d: got %b expected %b", i, bus.if_discard, (i < 3) ? 1'b1 : 1'b0);
            end
            tick();
            bus.inst_data_ok = 1'b0;
            tick();
        end
        checks++;
        if (bus.cancel_pending !== 1'b0) begin
            errors++; $display("FAIL br_drained: got %b expected 0", bus.cancel_pending);
        end
        // 7 outstanding plus the unreturned current one saturates at 7.
        idle();
        bus.id_valid       = 1'b1;
        bus.id_br_taken    = 1'b1;
        bus.if_outstanding = 3'd7;
        tick();
        idle();
        n_disc = 0;
        for (int i = 0; i < 8; i++) begin
            bus.inst_data_ok = 1'b1;
            #1;
            if (bus.if_discard === 1'b1) n_disc++;
            tick();
        end
        checks++;
        if (n_disc != 7) begin
            errors++; $display("FAIL br_saturate: got discards=%0d expected 7", n_disc);
        end
        idle();
    endtask

    task automatic test_flush();
        issue_write(5'd4, 4'd5);
        tick();
        issue_write(5'd9, VAR);
        tick();
        issue_write(5'd11, 4'd3);
        bus.flush          = 1'b1;
        bus.if_outstanding = 3'd1;
        bus.inst_data_ok   = 1'b1;
        #1;
        checks++;
        if ({bus.busy_vec[9], bus.busy_vec[4]} !== 2'b11 || bus.id_fire !== 1'b0) begin
            errors++; $display("FAIL flush_cycle: got busy9/4=%b%b fire=%b expected 11 0", bus.busy_vec[9], bus.busy_vec[4], bus.id_fire);
        end
        tick();
        idle();
        #1;
        checks++;
        if (bus.busy_vec !== 32'd0 || bus.cancel_pending !== 1'b1) begin
            errors++; $display("FAIL flush_after: got busy=%h pend=%b expected 0 1", bus.busy_vec, bus.cancel_pending);
        end
        bus.inst_data_ok = 1'b1;
        #1;
        checks++;
        if (bus.if_discard !== 1'b1) begin
            errors++; $display("FAIL flush_discard1: got %b expected 1", bus.if_discard);
        end
        tick();
        #1;
        checks++;
        if (bus.if_discard !== 1'b0) begin
            errors++; $display("FAIL flush_discard2: got %b expected 0", bus.if_discard);
        end
        tick();
        idle();
    endtask

    task automatic test_reset_mid();
        issue_write(5'd6, VAR);
        tick();
        idle();
        bus.id_valid       = 1'b1;
        bus.id_br_taken    = 1'b1;
        bus.if_outstanding = 3'd2;
        tick();
        idle();
        #1;
        checks++;
        if (bus.cancel_pending !== 1'b1 || bus.busy_vec[6] !== 1'b1) begin
            errors++; $display("FAIL rm_setup: got pend=%b busy6=%b expected 1 1", bus.cancel_pending, bus.busy_vec[6]);
        end
        // Reset must beat a simultaneous issue, branch load and wb_done.
        issue_write(5'd10, 4'd5);
        bus.id_br_taken    = 1'b1;
        bus.if_outstanding = 3'd4;
        bus.wb_done        = 1'b1;
        bus.wb_rd          = 5'd6;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        #1;
        checks++;
        if (bus.busy_vec !== 32'd0 || bus.cancel_pending !== 1'b0) begin
            errors++; $display("FAIL rm_cleared: got busy=%h pend=%b expected 0 0", bus.busy_vec, bus.cancel_pending);
        end
        bus.inst_data_ok = 1'b1;
        #1;
        checks++;
        if (bus.if_discard !== 1'b0) begin
            errors++; $display("FAIL rm_discard: got %b expected 0", bus.if_discard);
        end
        tick();
        idle();
    endtask

    task automatic test_back_to_back();
        idle();
        bus.id_valid    = 1'b1;
        bus.ex_allow_in = 1'b0;
        bus.id_rj       = 5'd12;
        bus.id_use_rj   = 1'b1;
        #1;
        checks++;
        if (bus.id_stall !== 1'b0 || bus.id_fire !== 1'b0) begin
            errors++; $display("FAIL ex_block: got stall=%b fire=%b expected 0 0", bus.id_stall, bus.id_fire);
        end
        // Two consecutive lat=1 writes; a reader right after the second stalls one cycle.
        issue_write(5'd13, 4'd1);
        tick();
        issue_write(5'd14, 4'd1);
        #1;
        checks++;
        if (bus.id_fire !== 1'b1 || bus.busy_vec[13] !== 1'b1) begin
            errors++; $display("FAIL b2b_second: got fire=%b busy13=%b expected 1 1", bus.id_fire, bus.busy_vec[13]);
        end
        tick();
        idle();
        bus.id_valid  = 1'b1;
        bus.id_rj     = 5'd13;
        bus.id_rk     = 5'd14;
        bus.id_use_rj = 1'b1;
        bus.id_use_rk = 1'b1;
        #1;
        checks++;
        if (bus.id_stall !== 1'b1 || bus.busy_vec[14:13] !== 2'b10) begin
            errors++; $display("FAIL b2b_reader: got stall=%b busy14:13=%b expected 1 10", bus.id_stall, bus.busy_vec[14:13]);
        end
        tick();
        checks++;
        if (bus.id_stall !== 1'b0 || bus.id_fire !== 1'b1) begin
            errors++; $display("FAIL b2b_release: got stall=%b fire=%b expected 0 1", bus.id_stall, bus.id_fire);
        end
        tick();
        idle();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_var_latency();
        test_r0_priority();
        test_branch_cancel();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
